tl_rx_credit_overflow_tracker: RTL

Sequential, multi-class receiver-overflow checker for the TL RX write path. It keeps a modular CREDITS_RECEIVED counter for header and data credits in each flow-control class. Every accepted TLP is checked against the CREDITS_ALLOCATED values published by the RX credit advertiser. A TLP that would overflow the receive buffers produces a registered error and is excluded from the counters.

---
 rtl/tl_rx_credit_overflow_tracker.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/tl_rx_credit_overflow_tracker.sv
// TL RX receiver-overflow checker: per-class CREDITS_RECEIVED tracking and a two-stage overflow compare.
// Optional build macro TL_RX_OVF_INFINITE_CREDIT_EN: a zero allocation means infinite credits for that check.
module tl_rx_credit_overflow_tracker #(
    parameter int NUM_FC_TYPES     = 3,
    parameter int HDR_CREDS_WIDTH  = 12,
    parameter int DATA_CREDS_WIDTH = 16,
    parameter int LEN_DW_WIDTH     = 11
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       fc_init,
    input  logic                                       overflow_en,
    input  logic                                       tlp_valid,
    input  logic [1:0]                                 tlp_fc_type,
    input  logic                                       tlp_has_data,
    input  logic [LEN_DW_WIDTH-1:0]                    tlp_len_dw,
    input  logic [2*NUM_FC_TYPES-1:0]                  hdr_scale,
    input  logic [2*NUM_FC_TYPES-1:0]                  data_scale,
    input  logic [HDR_CREDS_WIDTH*NUM_FC_TYPES-1:0]    alloc_hdr,
    input  logic [DATA_CREDS_WIDTH*NUM_FC_TYPES-1:0]   alloc_data,
    input  logic [NUM_FC_TYPES-1:0]                    status_clr,
    output logic                                       ovf_valid,
    output logic [1:0]                                 ovf_fc_type,
    output logic                                       ovf_hdr,
    output logic                                       ovf_data,
    output logic [NUM_FC_TYPES-1:0]                    ovf_status
);
    localparam int HW  = HDR_CREDS_WIDTH;
    localparam int DW  = DATA_CREDS_WIDTH;
    localparam int LW  = LEN_DW_WIDTH;
    localparam int LW1 = LEN_DW_WIDTH + 1;

    localparam logic [HW-1:0]  HMASK_8  = HW'(255);
    localparam logic [HW-1:0]  HMASK_10 = HW'(1023);
    localparam logic [HW-1:0]  HMASK_12 = HW'(4095);
    localparam logic [DW-1:0]  DMASK_12 = DW'(4095);
    localparam logic [DW-1:0]  DMASK_14 = DW'(16383);
    localparam logic [DW-1:0]  DMASK_16 = DW'(65535);
    localparam logic [LW1-1:0] RND_4    = LW1'(3);
    localparam logic [LW1-1:0] RND_16   = LW1'(15);
    localparam logic [LW1-1:0] RND_64   = LW1'(63);

    logic                    s1_valid_reg;
    logic [1:0]              s1_type_reg;
    logic [DW-1:0]           s1_req_data_reg;
    logic [1:0]              in_data_scale;
    logic [LW1-1:0]          len_round;
    logic [LW1-1:0]          req_quot;
    logic [DW-1:0]           req_data_next;
    logic                    tlp_in_range;

    logic [NUM_FC_TYPES-1:0] hdr_fail_vec;
    logic [NUM_FC_TYPES-1:0] data_fail_vec;
    logic [NUM_FC_TYPES-1:0] err_vec;

    logic                    ovf_valid_reg;
    logic [1:0]              ovf_fc_type_reg;
    logic                    ovf_hdr_reg;
    logic                    ovf_data_reg;
    logic [NUM_FC_TYPES-1:0] ovf_status_reg;

    assign tlp_in_range = int'(tlp_fc_type) < NUM_FC_TYPES;

    always_comb begin
        in_data_scale = 2'b00;
        for (int i = 0; i < NUM_FC_TYPES; i++) begin
            if (int'(tlp_fc_type) == i) in_data_scale = data_scale[2*i +: 2];
        end
    end

    // Required data credits: ceil(len / unit) via round-up add then shift.
    always_comb begin
        len_round = '0;
        req_quot  = '0;
        case (in_data_scale)
            2'b10: begin
                len_round = {1'b0, tlp_len_dw} + RND_16;
                req_quot  = len_round >> 4;
            end
            2'b11: begin
                len_round = {1'b0, tlp_len_dw} + RND_64;
                req_quot  = len_round >> 6;
            end
            default: begin
                len_round = {1'b0, tlp_len_dw} + RND_4;
                req_quot  = len_round >> 2;
            end
        endcase
        req_data_next = tlp_has_data ? DW'(req_quot) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || fc_init) begin
            s1_valid_reg    <= 1'b0;
            s1_type_reg     <= 2'b00;
            s1_req_data_reg <= '0;
        end else begin
            s1_valid_reg    <= tlp_valid && tlp_in_range;
            s1_type_reg     <= tlp_fc_type;
            s1_req_data_reg <= req_data_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FC_TYPES; gi++) begin : g_class
            logic [1:0]    hs;
            logic [1:0]    ds;
            logic [HW-1:0] hdr_mask;
            logic [DW-1:0] data_mask;
            logic [HW-1:0] alloc_h;
            logic [DW-1:0] alloc_d;
            logic [HW-1:0] hdr_res;
            logic [DW-1:0] data_res;
            logic [HW-1:0] cr_hdr_reg;
            logic [DW-1:0] cr_data_reg;
            logic          hdr_neg;
            logic          data_neg;
            logic          hdr_fail;
            logic          data_fail;
            logic          hit;
            logic          err;
            logic          upd;

            assign hs      = hdr_scale[2*gi +: 2];
            assign ds      = data_scale[2*gi +: 2];
            assign alloc_h = alloc_hdr[HW*gi +: HW];
            assign alloc_d = alloc_data[DW*gi +: DW];

            always_comb begin
                case (hs)
                    2'b10:   hdr_mask = HMASK_10;
                    2'b11:   hdr_mask = HMASK_12;
                    default: hdr_mask = HMASK_8;
                endcase
                case (ds)
                    2'b10:   data_mask = DMASK_14;
                    2'b11:   data_mask = DMASK_16;
                    default: data_mask = DMASK_12;
                endcase
            end

            assign hdr_res  = (alloc_h - (cr_hdr_reg + HW'(1))) & hdr_mask;
            assign data_res = (alloc_d - (cr_data_reg + s1_req_data_reg)) & data_mask;
            // Top bit of the F-bit field is the only mask bit not present in mask>>1.
            assign hdr_neg  = |(hdr_res & ~(hdr_mask >> 1));
            assign data_neg = |(data_res & ~(data_mask >> 1));

`ifdef TL_RX_OVF_INFINITE_CREDIT_EN
            assign hdr_fail  = hdr_neg && (alloc_h != '0);
            assign data_fail = data_neg && (s1_req_data_reg != '0) && (alloc_d != '0);
`else
            assign hdr_fail  = hdr_neg;
            assign data_fail = data_neg && (s1_req_data_reg != '0);
`endif

            assign hit = s1_valid_reg && (int'(s1_type_reg) == gi) && !fc_init;
            assign err = hit && overflow_en && (hdr_fail || data_fail);
            assign upd = hit && !err;

            assign hdr_fail_vec[gi]  = hdr_fail;
            assign data_fail_vec[gi] = data_fail;
            assign err_vec[gi]       = err;

            always_ff @(posedge clk) begin
                if (rst || fc_init) begin
                    cr_hdr_reg  <= '0;
                    cr_data_reg <= '0;
                end else if (upd) begin
                    cr_hdr_reg  <= (cr_hdr_reg + HW'(1)) & hdr_mask;
                    cr_data_reg <= (cr_data_reg + s1_req_data_reg) & data_mask;
                end
            end
        end
    endgenerate

    // At most one class is active in S2, so the OR-reductions select that class.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_valid_reg   <= 1'b0;
            ovf_fc_type_reg <= 2'b00;
            ovf_hdr_reg     <= 1'b0;
            ovf_data_reg    <= 1'b0;
            ovf_status_reg  <= '0;
        end else begin
            ovf_valid_reg  <= |err_vec;
            ovf_hdr_reg    <= |(err_vec & hdr_fail_vec);
            ovf_data_reg   <= |(err_vec & data_fail_vec);
            if (|err_vec) ovf_fc_type_reg <= s1_type_reg;
            ovf_status_reg <= (ovf_status_reg & ~status_clr) | err_vec;
        end
    end

    assign ovf_valid   = ovf_valid_reg;
    assign ovf_fc_type = ovf_fc_type_reg;
    assign ovf_hdr     = ovf_hdr_reg;
    assign ovf_data    = ovf_data_reg;
    assign ovf_status  = ovf_status_reg;

endmodule
